// File: rtl/regfile_mp.sv
`default_nettype none
// regfile_mp: NREAD combinational read ports, one synchronous write port, an
// optional hardwired-zero register and a sweep that defines every register after reset.
module regfile_mp #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 5,
    parameter int NREAD     = 2,
    parameter int ZERO_EN   = 1,
    parameter int ZERO_IDX  = 31,
    parameter int INIT_MODE = 1,
    parameter int BYPASS    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREAD*ADDR_W-1:0] raddr,
    output logic [NREAD*DATA_W-1:0] rdata,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    init_req,
    output logic                    ready,
    output logic                    wr_drop
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH-1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic                ready_q;
    logic                wr_drop_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   init_val;
    logic                wr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            ptr_q     <= '0;
            ready_q   <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            case (state_q)
                S_INIT: begin
                    // ptr wraps to zero on the final sweep write
                    ptr_q     <= ptr_q + 1'b1;
                    wr_drop_q <= we;
                    if (ptr_q == PTR_LAST) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    wr_drop_q <= 1'b0;
                    if (init_req) begin
                        state_q <= S_INIT;
                        ptr_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign init_val = (INIT_MODE != 0) ? DATA_W'(ptr_q) : '0;
    assign wr_ok    = we && !((ZERO_EN != 0) && (waddr == ZERO_ADDR));

    // Storage is deliberately unreset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem_q[ptr_q] <= init_val;
        end else if (wr_ok) begin
            mem_q[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem_q[ra];
            if (!ready_q) begin
                rd = '0;
            end else if ((ZERO_EN != 0) && (ra == ZERO_ADDR)) begin
                rd = '0;
            end else if ((BYPASS != 0) && we && (waddr == ra)) begin
                rd = wdata;
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = rd;
    end

    assign ready   = ready_q;
    assign wr_drop = wr_drop_q;

endmodule
`default_nettype wire
